// File: rtl/glyph_renderer.sv
// glyph_renderer: on-screen character generator for the VGA calculator display.
// Draws one 5x5 font glyph, scaled by 2^SCALE_LOG2, in a box at (X0, Y0).
// The glyph code and blink enable are shadowed at frame_tick so the glyph never
// changes mid-frame. A frame counter provides an optional blink.
//
// Ports:
//   clk         pixel clock
//   reset       asynchronous, active-high reset
//   pixel_x/y   current raster coordinate from VGA sync
//   video_on    active-video flag from VGA sync
//   frame_tick  one-cycle pulse at start of vertical blank
//   glyph_sel   requested glyph code (sampled on frame_tick only)
//   blink_en    blink enable (sampled on frame_tick only)
//   pixel_on    registered glyph foreground bit, 2 clocks after the coordinate
//   pixel_valid video_on delayed to line up with pixel_on
module glyph_renderer #(
    parameter int COORD_W    = 10,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int SCALE_LOG2 = 2,
    parameter int BLINK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic [3:0]         glyph_sel,
    input  logic               blink_en,
    output logic               pixel_on,
    output logic               pixel_valid
);

    // Geometry is evaluated in 32 bits so X0+SPAN can never wrap the coordinate width.
    localparam logic [31:0] SPAN_U = 32'(5 << SCALE_LOG2);
    localparam logic [31:0] X0_U   = 32'(X0);
    localparam logic [31:0] Y0_U   = 32'(Y0);

    // Font ROM indexed by {glyph,row}; bit 4 is the leftmost column.
    // Rows not listed (including rows 5..7 and the blank glyph) read as zero.
    function automatic logic [4:0] font_row(input logic [3:0] glyph, input logic [2:0] row);
        logic [4:0] r;
        r = 5'h00;
        case ({glyph, row})
            7'h00: r = 5'h0E; 7'h01: r = 5'h11; 7'h02: r = 5'h11; 7'h03: r = 5'h11; 7'h04: r = 5'h0E;
            7'h08: r = 5'h04; 7'h09: r = 5'h0C; 7'h0A: r = 5'h04; 7'h0B: r = 5'h04; 7'h0C: r = 5'h0E;
            7'h10: r = 5'h0E; 7'h11: r = 5'h11; 7'h12: r = 5'h02; 7'h13: r = 5'h04; 7'h14: r = 5'h1F;
            7'h18: r = 5'h1E; 7'h19: r = 5'h01; 7'h1A: r = 5'h0E; 7'h1B: r = 5'h01; 7'h1C: r = 5'h1E;
            7'h20: r = 5'h11; 7'h21: r = 5'h11; 7'h22: r = 5'h1F; 7'h23: r = 5'h01; 7'h24: r = 5'h01;
            7'h28: r = 5'h1F; 7'h29: r = 5'h10; 7'h2A: r = 5'h1E; 7'h2B: r = 5'h01; 7'h2C: r = 5'h1E;
            7'h30: r = 5'h0E; 7'h31: r = 5'h10; 7'h32: r = 5'h1E; 7'h33: r = 5'h11; 7'h34: r = 5'h0E;
            7'h38: r = 5'h1F; 7'h39: r = 5'h01; 7'h3A: r = 5'h02; 7'h3B: r = 5'h04; 7'h3C: r = 5'h04;
            7'h40: r = 5'h0E; 7'h41: r = 5'h11; 7'h42: r = 5'h0E; 7'h43: r = 5'h11; 7'h44: r = 5'h0E;
            7'h48: r = 5'h0E; 7'h49: r = 5'h11; 7'h4A: r = 5'h0F; 7'h4B: r = 5'h01; 7'h4C: r = 5'h0E;
            7'h50: r = 5'h04; 7'h51: r = 5'h04; 7'h52: r = 5'h1F; 7'h53: r = 5'h04; 7'h54: r = 5'h04;
            7'h5A: r = 5'h1F;
            7'h60: r = 5'h15; 7'h61: r = 5'h0E; 7'h62: r = 5'h1F; 7'h63: r = 5'h0E; 7'h64: r = 5'h15;
            7'h68: r = 5'h01; 7'h69: r = 5'h02; 7'h6A: r = 5'h04; 7'h6B: r = 5'h08; 7'h6C: r = 5'h10;
            7'h71: r = 5'h1F; 7'h73: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [3:0]            shadow_glyph_r;
    logic                  shadow_blink_r;
    logic [BLINK_LOG2-1:0] blink_cnt_r;

    logic [31:0] x_s;
    logic [31:0] y_s;
    logic        in_box_s;
    logic [2:0]  col_s;
    logic [2:0]  row_s;
    logic        visible_s;

    logic        s1_in_box_r;
    logic [2:0]  s1_col_r;
    logic [2:0]  s1_row_r;
    logic        s1_video_r;
    logic [3:0]  s1_glyph_r;
    logic        s1_visible_r;

    logic [4:0]  bits_s;
    logic [4:0]  sel_s;
    logic        on_s;

    // Box test and cell coordinates; the bounds are checked before subtracting so
    // col/row only matter when in_box is set and never come from an underflow.
    always_comb begin
        x_s       = 32'(pixel_x);
        y_s       = 32'(pixel_y);
        in_box_s  = 1'b0;
        if (video_on && (x_s >= X0_U) && (x_s < X0_U + SPAN_U) &&
            (y_s >= Y0_U) && (y_s < Y0_U + SPAN_U)) begin
            in_box_s = 1'b1;
        end else begin
            in_box_s = 1'b0;
        end
        col_s     = 3'((x_s - X0_U) >> SCALE_LOG2);
        row_s     = 3'((y_s - Y0_U) >> SCALE_LOG2);
        visible_s = !shadow_blink_r || !blink_cnt_r[BLINK_LOG2-1];
    end

    // Frame-synchronous shadow of glyph/blink request plus the blink frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_glyph_r <= 4'd15;
            shadow_blink_r <= 1'b0;
            blink_cnt_r    <= '0;
        end else if (frame_tick) begin
            shadow_glyph_r <= glyph_sel;
            shadow_blink_r <= blink_en;
            blink_cnt_r    <= blink_cnt_r + 1'b1;
        end else begin
            shadow_glyph_r <= shadow_glyph_r;
            shadow_blink_r <= shadow_blink_r;
            blink_cnt_r    <= blink_cnt_r;
        end
    end

    // Stage 1: register geometry and the shadow state seen by this pixel
    // (a pixel coinciding with frame_tick still sees the old shadow values).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_in_box_r  <= 1'b0;
            s1_col_r     <= 3'd0;
            s1_row_r     <= 3'd0;
            s1_video_r   <= 1'b0;
            s1_glyph_r   <= 4'd0;
            s1_visible_r <= 1'b0;
        end else begin
            s1_in_box_r  <= in_box_s;
            s1_col_r     <= col_s;
            s1_row_r     <= row_s;
            s1_video_r   <= video_on;
            s1_glyph_r   <= shadow_glyph_r;
            s1_visible_r <= visible_s;
        end
    end

    // Font lookup and column select; a column outside 0..4 shifts all bits out.
    always_comb begin
        bits_s = font_row(s1_glyph_r, s1_row_r);
        sel_s  = bits_s >> (3'd4 - s1_col_r);
        on_s   = s1_in_box_r && s1_visible_r && sel_s[0];
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_on    <= on_s;
            pixel_valid <= s1_video_r;
        end
    end

endmodule

// File: tb/tb_glyph_renderer.sv
// Scoreboard bench for glyph_renderer: three instances with different origin,
// scale and blink parameters share the raster inputs. The driver pushes the
// expected pixel_on/pixel_valid for every instance; a monitor pops and compares
// each entry two clocks later.
module tb_glyph_renderer;

    logic       clk;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       frame_tick;
    logic [3:0] glyph_sel [3];
    logic       blink_en  [3];
    logic [2:0] pon;
    logic [2:0] pval;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        logic [2:0] on;
        logic       valid;
        int         due;
    } exp_t;
    exp_t sbq[$];

    // Bench-side parameters of each instance
    int mx0 [3] = '{0, 100, 10};
    int my0 [3] = '{0, 50, 10};
    int msc [3] = '{0, 2, 0};
    int mbl [3] = '{5, 2, 2};

    // Hand-entered font table, rows top to bottom, bit 4 leftmost
    logic [4:0] font [16][5] = '{
        '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h02, 5'h04, 5'h1F},
        '{5'h1E, 5'h01, 5'h0E, 5'h01, 5'h1E},
        '{5'h11, 5'h11, 5'h1F, 5'h01, 5'h01},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h1E},
        '{5'h0E, 5'h10, 5'h1E, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h04},
        '{5'h0E, 5'h11, 5'h0E, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h0F, 5'h01, 5'h0E},
        '{5'h04, 5'h04, 5'h1F, 5'h04, 5'h04},
        '{5'h00, 5'h00, 5'h1F, 5'h00, 5'h00},
        '{5'h15, 5'h0E, 5'h1F, 5'h0E, 5'h15},
        '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10},
        '{5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00},
        '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00}
    };

    // Model state per instance
    int sg  [3];
    bit sb  [3];
    int cnt [3];

    glyph_renderer #(.COORD_W(10), .X0(0), .Y0(0), .SCALE_LOG2(0), .BLINK_LOG2(5)) u_a (
        .clk(clk), .reset(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_tick(frame_tick), .glyph_sel(glyph_sel[0]), .blink_en(blink_en[0]),
        .pixel_on(pon[0]), .pixel_valid(pval[0]));

    glyph_renderer #(.COORD_W(10), .X0(100), .Y0(50), .SCALE_LOG2(2), .BLINK_LOG2(2)) u_b (
        .clk(clk), .reset(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_tick(frame_tick), .glyph_sel(glyph_sel[1]), .blink_en(blink_en[1]),
        .pixel_on(pon[1]), .pixel_valid(pval[1]));

    glyph_renderer #(.COORD_W(10), .X0(10), .Y0(10), .SCALE_LOG2(0), .BLINK_LOG2(2)) u_c (
        .clk(clk), .reset(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_tick(frame_tick), .glyph_sel(glyph_sel[2]), .blink_en(blink_en[2]),
        .pixel_on(pon[2]), .pixel_valid(pval[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_on(int i, int x, int y, bit vid);
        int  span;
        int  col;
        int  row;
        bit  vis;
        logic [4:0] bits;
        span = 5 << msc[i];
        if (!vid || x < mx0[i] || x >= mx0[i] + span || y < my0[i] || y >= my0[i] + span)
            return 1'b0;
        col  = (x - mx0[i]) >> msc[i];
        row  = (y - my0[i]) >> msc[i];
        vis  = !sb[i] || (((cnt[i] >> (mbl[i] - 1)) & 1) == 0);
        bits = font[sg[i]][row];
        return vis && bits[4 - col];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            sg[i]  = 15;
            sb[i]  = 1'b0;
            cnt[i] = 0;
        end
    endtask

    task automatic check_bit(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0b required %0b", name, act, req);
        end
    endtask

    // Monitor: pop every entry whose output is due and compare all instances
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e = sbq.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        check_bit($sformatf("pixel_on[%0d] cyc %0d", i, e.due), pon[i], e.on[i]);
                        check_bit($sformatf("pixel_valid[%0d] cyc %0d", i, e.due), pval[i], e.valid);
                    end
                end
            end
        end
    endtask

    // Drive one pixel for one clock and push its expected response
    task automatic drive(int x, int y, bit vid, bit tick);
        exp_t e;
        @(posedge clk);
        #1;
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        video_on   = vid;
        frame_tick = tick;
        for (int i = 0; i < 3; i++) e.on[i] = model_on(i, x, y, vid);
        e.valid = vid;
        e.due   = cyc + 2;
        sbq.push_back(e);
        if (tick) begin
            for (int i = 0; i < 3; i++) begin
                sg[i]  = int'(glyph_sel[i]);
                sb[i]  = blink_en[i];
                cnt[i] = (cnt[i] + 1) % (1 << mbl[i]);
            end
        end
    endtask

    task automatic scan(int xa, int xb, int ya, int yb, bit vid);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) drive(x, y, vid, 1'b0);
            drive(0, 0, 1'b0, 1'b0);    // horizontal blank
        end
    endtask

    task automatic tick();
        drive(0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        pixel_x    = 10'd0;
        pixel_y    = 10'd0;
        video_on   = 1'b0;
        frame_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            glyph_sel[i] = 4'd0;
            blink_en[i]  = 1'b0;
        end
        model_reset();
        fork
            monitor();
        join_none

        // Reset state
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_bit($sformatf("reset pixel_on[%0d]", i), pon[i], 1'b0);
            check_bit($sformatf("reset pixel_valid[%0d]", i), pval[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // '+' at origin scale 1, '-' at (100,50) scale 4, '4' at (10,10)
        glyph_sel[0] = 4'd10; glyph_sel[1] = 4'd11; glyph_sel[2] = 4'd4;
        tick();
        scan(0, 6, 0, 6, 1'b1);
        scan(98, 121, 48, 71, 1'b1);
        scan(8, 16, 8, 16, 1'b1);

        // Mid-frame change without frame_tick must not take effect
        glyph_sel[0] = 4'd1;
        tick();
        scan(0, 6, 0, 6, 1'b1);
        glyph_sel[0] = 4'd12;
        scan(0, 6, 0, 6, 1'b1);
        tick();
        scan(0, 6, 0, 6, 1'b1);

        // frame_tick on an active pixel: that pixel still uses '*', then '8'
        glyph_sel[0] = 4'd8;
        drive(1, 0, 1'b1, 1'b1);
        drive(1, 0, 1'b1, 1'b0);

        // Blink on instance b: 2 frames visible, 2 blank
        glyph_sel[1] = 4'd8; blink_en[1] = 1'b1;
        for (int f = 0; f < 6; f++) begin
            tick();
            scan(98, 121, 48, 71, 1'b1);
        end
        blink_en[1] = 1'b0;
        for (int f = 0; f < 3; f++) begin
            tick();
            scan(100, 119, 50, 69, 1'b1);
        end

        // Blank glyph, then video_on low across the box
        glyph_sel[0] = 4'd15;
        tick();
        scan(0, 6, 0, 6, 1'b1);
        glyph_sel[0] = 4'd8;
        tick();
        scan(0, 6, 0, 6, 1'b0);

        // Reset mid-line while pixel_on is high
        for (int k = 0; k < 4; k++) drive(1, 0, 1'b1, 1'b0);
        @(negedge clk);
        check_bit("pre-reset pixel_on[0]", pon[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("async reset pixel_on[0]", pon[0], 1'b0);
        check_bit("async reset pixel_valid[0]", pval[0], 1'b0);
        sbq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(1, 0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) drive(1, 0, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 8 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain actual %0d pending required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
